// File: rtl/regfile_wb_pkg.sv
// Shared defaults and types for the register-file writeback driver.
package regfile_wb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_MD_DEPTH = 2;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  live;
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// Ordered queue of multiply/divide results with kill-by-index and a
// youngest-match lookup used for decode bypass.
module wb_fifo2
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_MD_DEPTH,
  parameter bit LOOKUP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_rd,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [ADDR_W-1:0] i_kill_rd,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_head_live,
  output logic [ADDR_W-1:0] o_head_rd,
  output logic [DATA_W-1:0] o_head_data,
  input  logic [ADDR_W-1:0] i_qa,
  input  logic [ADDR_W-1:0] i_qb,
  output logic              o_qa_hit,
  output logic [DATA_W-1:0] o_qa_data,
  output logic              o_qb_hit,
  output logic [DATA_W-1:0] o_qb_data
);

  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Entry 0 is the head; slots at or beyond r_cnt always hold live=0.
  entry_t           r_q     [DEPTH];
  entry_t           w_q_nxt [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_wr_idx;

  assign w_wr_idx = i_pop ? (r_cnt - 1'b1) : r_cnt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_q_nxt = r_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_kill_en && r_q[i].live && (r_q[i].rd == i_kill_rd)) w_q_nxt[i].live = 1'b0;
    end
    if (i_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) w_q_nxt[i] = w_q_nxt[i+1];
      w_q_nxt[DEPTH-1] = '0;
    end
    if (i_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == w_wr_idx) w_q_nxt[i] = '{live: 1'b1, rd: i_push_rd, data: i_push_data};
      end
    end
  end

  always_comb begin
    unique case ({i_push, i_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // NOTE: the queue storage is reset because the live bits carry state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_q_nxt[i];
    end
  end

  assign o_full      = (r_cnt == DEPTH_C);
  assign o_empty     = (r_cnt == '0);
  assign o_head_live = r_q[0].live;
  assign o_head_rd   = r_q[0].rd;
  assign o_head_data = r_q[0].data;

  generate
    if (LOOKUP_EN) begin : g_lookup
      // Later slots are younger, so the last match wins.
      always_comb begin
        o_qa_hit  = 1'b0;
        o_qa_data = '0;
        o_qb_hit  = 1'b0;
        o_qb_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (r_q[i].live && (r_q[i].rd == i_qa)) begin
            o_qa_hit  = 1'b1;
            o_qa_data = r_q[i].data;
          end
          if (r_q[i].live && (r_q[i].rd == i_qb)) begin
            o_qb_hit  = 1'b1;
            o_qb_data = r_q[i].data;
          end
        end
      end
    end else begin : g_no_lookup
      logic w_unused_q;
      assign w_unused_q = ^{i_qa, i_qb};
      assign o_qa_hit   = 1'b0;
      assign o_qa_data  = '0;
      assign o_qb_hit   = 1'b0;
      assign o_qb_data  = '0;
    end
  endgenerate

endmodule

// File: rtl/regfile_wb.sv
// Register-file writeback driver: merges pipeline and mult/div results into
// one write per cycle. Decode bypass is built only with REGFILE_WB_BYPASS_EN.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MD_DEPTH = DEF_MD_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wr,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_valid,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              RegWr,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [DATA_W-1:0] busW,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              fwdA_hit,
  output logic              fwdB_hit,
  output logic [DATA_W-1:0] fwdA,
  output logic [DATA_W-1:0] fwdB
);

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic              w_pipe_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_head_live;
  logic [ADDR_W-1:0] w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic              w_qa_hit;
  logic              w_qb_hit;
  logic [DATA_W-1:0] w_qa_data;
  logic [DATA_W-1:0] w_qb_data;

  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_wr_rd;
  logic [DATA_W-1:0] r_bus_w;

  assign w_pipe_issue = pipe_wr && (pipe_rd != ZERO_IDX);
  assign md_ready     = !w_full && !rst;
  // A result whose register the pipeline overwrites this cycle is already dead.
  assign w_push       = md_valid && md_ready && (md_rd != ZERO_IDX)
                        && !(w_pipe_issue && (pipe_rd == md_rd));
  assign w_pop        = !w_pipe_issue && !w_empty;

  wb_fifo2 #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (MD_DEPTH),
    .LOOKUP_EN(BYPASS_EN)
  ) u_md_q (
    .clk        (clk),
    .i_rst      (rst),
    .i_push     (w_push),
    .i_push_rd  (md_rd),
    .i_push_data(md_data),
    .i_pop      (w_pop),
    .i_kill_en  (w_pipe_issue),
    .i_kill_rd  (pipe_rd),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_live(w_head_live),
    .o_head_rd  (w_head_rd),
    .o_head_data(w_head_data),
    .i_qa       (rs),
    .i_qb       (rt),
    .o_qa_hit   (w_qa_hit),
    .o_qa_data  (w_qa_data),
    .o_qb_hit   (w_qb_hit),
    .o_qb_data  (w_qb_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg_wr <= 1'b0;
      r_wr_rd  <= '0;
      r_bus_w  <= '0;
    end else if (w_pipe_issue) begin
      r_reg_wr <= 1'b1;
      r_wr_rd  <= pipe_rd;
      r_bus_w  <= pipe_data;
    end else if (w_pop && w_head_live) begin
      r_reg_wr <= 1'b1;
      r_wr_rd  <= w_head_rd;
      r_bus_w  <= w_head_data;
    end else begin
      r_reg_wr <= 1'b0;
    end
  end

  assign RegWr = r_reg_wr;
  assign wr_rd = r_wr_rd;
  assign busW  = r_bus_w;

`ifdef REGFILE_WB_BYPASS_EN
  // Queue entries are younger than the output register, so they win.
  always_comb begin
    fwdA_hit = 1'b0;
    fwdA     = '0;
    fwdB_hit = 1'b0;
    fwdB     = '0;
    if (rs != ZERO_IDX) begin
      if (w_qa_hit) begin
        fwdA_hit = 1'b1;
        fwdA     = w_qa_data;
      end else if (r_reg_wr && (r_wr_rd == rs)) begin
        fwdA_hit = 1'b1;
        fwdA     = r_bus_w;
      end
    end
    if (rt != ZERO_IDX) begin
      if (w_qb_hit) begin
        fwdB_hit = 1'b1;
        fwdB     = w_qb_data;
      end else if (r_reg_wr && (r_wr_rd == rt)) begin
        fwdB_hit = 1'b1;
        fwdB     = r_bus_w;
      end
    end
  end
`else
  logic w_unused_byp;
  assign w_unused_byp = ^{w_qa_hit, w_qa_data, w_qb_hit, w_qb_data};
  assign fwdA_hit     = 1'b0;
  assign fwdB_hit     = 1'b0;
  assign fwdA         = '0;
  assign fwdB         = '0;
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb; bypass expectations follow REGFILE_WB_BYPASS_EN.
module tb_regfile_wb;
  import regfile_wb_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic        RegWr;
  logic [4:0]  wr_rd;
  logic [31:0] busW;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        fwdA_hit;
  logic        fwdB_hit;
  logic [31:0] fwdA;
  logic [31:0] fwdB;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb #(.DATA_W(32), .ADDR_W(5), .MD_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr(pipe_wr), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .RegWr(RegWr), .wr_rd(wr_rd), .busW(busW),
    .rs(rs), .rt(rt),
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA(fwdA), .fwdB(fwdB)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wr = 1'b0; pipe_rd = '0; pipe_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
  endtask

  task automatic test_reset();
    logic [37:0] exp_o;
    idle(); rs = '0; rt = '0; rst = 1'b1;
    step(); step();
    n_cmp++;
    if (md_ready !== 1'b0) begin n_bad++; $display("FAIL rst_md_ready: got %b want 0", md_ready); end
    exp_o = '0;
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== exp_o) begin
      n_bad++; $display("FAIL rst_out: got %h want %h", {RegWr, wr_rd, busW}, exp_o);
    end
    n_cmp++;
    if ({fwdA_hit, fwdB_hit} !== 2'b00) begin
      n_bad++; $display("FAIL rst_fwd_hit: got %b want 00", {fwdA_hit, fwdB_hit});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (md_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", md_ready); end
  endtask

  task automatic test_pipe_write();
    logic [32:0] exp_f;
    idle(); rs = 5'd5; rt = 5'd6;
    pipe_wr = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
    step(); idle();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd5, 32'h1234}) begin
      n_bad++; $display("FAIL pipe_out: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd5, 32'h1234});
    end
    exp_f = BYP ? {1'b1, 32'h1234} : 33'h0;
    n_cmp++;
    if ({fwdA_hit, fwdA} !== exp_f) begin
      n_bad++; $display("FAIL pipe_fwdA: got %h want %h", {fwdA_hit, fwdA}, exp_f);
    end
    n_cmp++;
    if ({fwdB_hit, fwdB} !== 33'h0) begin
      n_bad++; $display("FAIL pipe_fwdB_miss: got %h want 0", {fwdB_hit, fwdB});
    end
    step();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b0, 5'd5, 32'h1234}) begin
      n_bad++; $display("FAIL pipe_hold: got %h want %h", {RegWr, wr_rd, busW}, {1'b0, 5'd5, 32'h1234});
    end
  endtask

  task automatic test_md_delay();
    logic [32:0] exp_f;
    idle(); rs = 5'd7; rt = '0;
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hAAAA;
    n_cmp++;
    if (md_ready !== 1'b1) begin n_bad++; $display("FAIL md_ready_empty: got %b want 1", md_ready); end
    step();
    idle(); pipe_wr = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h33;
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL md_n1_idle: got %b want 0", RegWr); end
    exp_f = BYP ? {1'b1, 32'hAAAA} : 33'h0;
    n_cmp++;
    if ({fwdA_hit, fwdA} !== exp_f) begin
      n_bad++; $display("FAIL md_queue_fwd: got %h want %h", {fwdA_hit, fwdA}, exp_f);
    end
    step();
    pipe_rd = 5'd4; pipe_data = 32'h44;
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd3, 32'h33}) begin
      n_bad++; $display("FAIL md_pipe_r3: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd3, 32'h33});
    end
    step();
    idle();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd4, 32'h44}) begin
      n_bad++; $display("FAIL md_pipe_r4: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd4, 32'h44});
    end
    step();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd7, 32'hAAAA}) begin
      n_bad++; $display("FAIL md_r7_late: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd7, 32'hAAAA});
    end
    step();
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL md_drained: got %b want 0", RegWr); end
  endtask

  task automatic test_back_to_back();
    wb_entry_t md_vec [3];
    md_vec[0] = '{live: 1'b1, rd: 5'd20, data: 32'h200};
    md_vec[1] = '{live: 1'b1, rd: 5'd21, data: 32'h210};
    md_vec[2] = '{live: 1'b1, rd: 5'd22, data: 32'h220};
    idle(); rs = '0; rt = '0;
    for (int c = 0; c < 3; c++) begin
      pipe_wr = 1'b1; pipe_rd = 5'(10 + c); pipe_data = 32'(32'h100 + c);
      md_valid = 1'b1; md_rd = md_vec[c].rd; md_data = md_vec[c].data;
      n_cmp++;
      if (md_ready !== (c < 2)) begin
        n_bad++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, md_ready, (c < 2));
      end
      if (c > 0) begin
        n_cmp++;
        if ({RegWr, wr_rd, busW} !== {1'b1, 5'(10 + c - 1), 32'(32'h100 + c - 1)}) begin
          n_bad++; $display("FAIL b2b_pipe_c%0d: got %h", c, {RegWr, wr_rd, busW});
        end
      end
      step();
    end
    pipe_wr = 1'b0;
    n_cmp++;
    if (md_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_hold: got %b want 0", md_ready); end
    step();
    n_cmp++;
    if (md_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", md_ready); end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({RegWr, wr_rd, busW} !== {1'b1, md_vec[k].rd, md_vec[k].data}) begin
        n_bad++; $display("FAIL b2b_md_order%0d: got %h want %h", k, {RegWr, wr_rd, busW},
                          {1'b1, md_vec[k].rd, md_vec[k].data});
      end
      step();
      idle();
    end
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", RegWr); end
  endtask

  task automatic test_kill();
    logic [32:0] exp_f;
    idle(); rs = 5'd9; rt = '0;
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h1;
    step();
    idle(); pipe_wr = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h2;
    step();
    idle();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd9, 32'h2}) begin
      n_bad++; $display("FAIL kill_pipe_r9: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd9, 32'h2});
    end
    exp_f = BYP ? {1'b1, 32'h2} : 33'h0;
    n_cmp++;
    if ({fwdA_hit, fwdA} !== exp_f) begin
      n_bad++; $display("FAIL kill_fwd_r9: got %h want %h", {fwdA_hit, fwdA}, exp_f);
    end
    step();
    n_cmp++;
    if ({RegWr, fwdA_hit} !== 2'b00) begin
      n_bad++; $display("FAIL kill_no_write: got %b want 00", {RegWr, fwdA_hit});
    end
    step();
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL kill_no_late_write: got %b want 0", RegWr); end
    rs = 5'd13;
    md_valid = 1'b1; md_rd = 5'd13; md_data = 32'h5;
    pipe_wr = 1'b1; pipe_rd = 5'd13; pipe_data = 32'h6;
    step();
    idle();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd13, 32'h6}) begin
      n_bad++; $display("FAIL entry_kill_pipe: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd13, 32'h6});
    end
    step();
    n_cmp++;
    if ({RegWr, fwdA_hit} !== 2'b00) begin
      n_bad++; $display("FAIL entry_kill_dropped: got %b want 00", {RegWr, fwdA_hit});
    end
  endtask

  task automatic test_reg_zero();
    idle(); rs = '0; rt = '0;
    pipe_wr = 1'b1; pipe_rd = '0; pipe_data = 32'hDEAD;
    md_valid = 1'b1; md_rd = '0; md_data = 32'hBEEF;
    step();
    idle();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b0, 5'd13, 32'h6}) begin
      n_bad++; $display("FAIL zero_no_write: got %h want %h", {RegWr, wr_rd, busW}, {1'b0, 5'd13, 32'h6});
    end
    n_cmp++;
    if ({fwdA_hit, fwdB_hit} !== 2'b00) begin
      n_bad++; $display("FAIL zero_fwd_hit: got %b want 00", {fwdA_hit, fwdB_hit});
    end
    pipe_wr = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    md_valid = 1'b1; md_rd = 5'd14; md_data = 32'hE;
    step();
    for (int c = 0; c < 2; c++) begin
      md_rd = '0; md_data = 32'hF;
      n_cmp++;
      if (md_ready !== 1'b1) begin n_bad++; $display("FAIL zero_count_c%0d: got %b want 1", c, md_ready); end
      step();
    end
    idle();
    step();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd14, 32'hE}) begin
      n_bad++; $display("FAIL zero_real_md: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd14, 32'hE});
    end
    step();
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL zero_no_extra: got %b want 0", RegWr); end
  endtask

  task automatic test_bypass_youngest();
    logic [65:0] exp_ab;
    idle(); rs = '0; rt = '0;
    pipe_wr = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h2;
    md_valid = 1'b1; md_rd = 5'd18; md_data = 32'hA;
    step();
    md_data = 32'hB;
    step();
    idle(); rs = 5'd18; rt = 5'd18;
    n_cmp++;
    if (md_ready !== 1'b0) begin n_bad++; $display("FAIL young_full: got %b want 0", md_ready); end
    exp_ab = BYP ? {1'b1, 32'hB, 1'b1, 32'hB} : 66'h0;
    n_cmp++;
    if ({fwdA_hit, fwdA, fwdB_hit, fwdB} !== exp_ab) begin
      n_bad++; $display("FAIL young_fwd_q: got %h want %h", {fwdA_hit, fwdA, fwdB_hit, fwdB}, exp_ab);
    end
    step();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd18, 32'hA}) begin
      n_bad++; $display("FAIL young_wr_a: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd18, 32'hA});
    end
    n_cmp++;
    if ({fwdA_hit, fwdA, fwdB_hit, fwdB} !== exp_ab) begin
      n_bad++; $display("FAIL young_fwd_over_reg: got %h want %h", {fwdA_hit, fwdA, fwdB_hit, fwdB}, exp_ab);
    end
    step();
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== {1'b1, 5'd18, 32'hB}) begin
      n_bad++; $display("FAIL young_wr_b: got %h want %h", {RegWr, wr_rd, busW}, {1'b1, 5'd18, 32'hB});
    end
    step();
    n_cmp++;
    if (RegWr !== 1'b0) begin n_bad++; $display("FAIL young_drained: got %b want 0", RegWr); end
  endtask

  task automatic test_reset_mid();
    idle(); rs = 5'd16; rt = 5'd17;
    pipe_wr = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h3;
    md_valid = 1'b1; md_rd = 5'd16; md_data = 32'h16;
    step();
    md_rd = 5'd17; md_data = 32'h17;
    step();
    idle(); rst = 1'b1;
    #1;
    n_cmp++;
    if (md_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_in_rst: got %b want 0", md_ready); end
    step();
    rst = 1'b0;
    n_cmp++;
    if ({RegWr, wr_rd, busW} !== 38'h0) begin
      n_bad++; $display("FAIL rmid_out_cleared: got %h want 0", {RegWr, wr_rd, busW});
    end
    n_cmp++;
    if ({fwdA_hit, fwdB_hit} !== 2'b00) begin
      n_bad++; $display("FAIL rmid_fwd: got %b want 00", {fwdA_hit, fwdB_hit});
    end
    #1;
    n_cmp++;
    if (md_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after: got %b want 1", md_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (RegWr !== 1'b0) begin n_bad++; $display("FAIL rmid_stale_write%0d: got %b want 0", c, RegWr); end
    end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_md_delay();
    test_back_to_back();
    test_kill();
    test_reg_zero();
    test_bypass_youngest();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback driver for the register file's single write port. Sits at the end of the pipeline. Merges two sources into one write per cycle:
- the in-order pipeline's WB-stage result;
- results from the long-latency multiply/divide unit, held in a small ordered queue.

It also tracks unwritten results and supplies bypass data to the decode stage for the rs/rt read ports.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- MD_DEPTH, 2, multiply/divide result queue entries

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- pipe_wr  in  1  pipeline writeback valid; never stalled
- pipe_rd  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- md_valid  in  1  mult/div result valid
- md_rd  in  ADDR_W  mult/div destination register
- md_data  in  DATA_W  mult/div result
- md_ready  out  1  queue can accept; a transfer occurs when md_valid && md_ready
- RegWr  out  1  register file write enable (registered)
- wr_rd  out  ADDR_W  register file write index (registered)
- busW  out  DATA_W  register file write data (registered)
- rs, rt  in  ADDR_W  decode-stage read indices
- fwdA_hit, fwdB_hit  out  1  bypass valid for rs / rt
- fwdA, fwdB  out  DATA_W  bypass data for rs / rt

## Operation
Write issue:
- At most one write is issued per cycle.
- Priority 1: pipe_wr && pipe_rd!=0 issues the pipeline write.
- Priority 2: otherwise, if the queue is non-empty, the head entry issues.
- A killed head is popped with no write (RegWr=0 for that slot).
- Issued write is loaded into RegWr/wr_rd/busW. If nothing issues, RegWr=0 and wr_rd/busW hold their values.

Register 0 handling:
- pipe_rd==0: ignored.
- md_rd==0: accepted and discarded; uses no queue entry.

Queue:
- md_ready = (count < MD_DEPTH) && !rst.
- Depends only on the registered count; no same-cycle pop-through.
- Push and pop in the same cycle leave count unchanged.

Ordering and kill:
- The pipeline guarantees any mult/div result is older than a concurrent pipeline write.
- A pipeline write to X kills every live queue entry with rd==X.
- An md result to X accepted in the same cycle is also discarded (killed on entry).
- Killed entries never write.

Bypass:
- For each query index q (rs, rt), q!=0.
- Hit source 1: the youngest live queue entry with rd==q.
- Hit source 2: else, RegWr && wr_rd==q, giving busW.
- Else hit=0 and data=0.
- Combinational from registered state only.
- The register file covers all earlier writes.

Reset:
- Queue emptied, kill flags cleared.
- RegWr=0, wr_rd=0, busW=0, md_ready=0, fwd*_hit=0.
- Reset mid-operation discards queued results.

## Timing
- Pipeline write accepted cycle N: RegWr=1 in N+1; register file updated at the end of N+1.
- md result accepted cycle N (queue empty, no pipe write in N+1): RegWr=1 in N+2.
- Each pipe write in cycle N+1 delays the queue head by one cycle.
- Full queue: md_ready=0 until the cycle after the first pop.
- Bypass: the value is visible in the same cycle it enters the queue or output register (one cycle after accept).

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - queue and output-register bypass as described;
  - fwdA/fwdB/fwd*_hit live.
- Not defined:
  - fwd*_hit tied 0, fwdA/fwdB tied 0;
  - no compare logic is built;
  - decode must stall on pending registers.

## Structure
- Shared package holds:
  - DATA_W/ADDR_W/MD_DEPTH defaults;
  - wb_entry_t typedef {live, rd, data};
  - REG_ZERO constant.
- Sub-module wb_fifo2:
  - MD_DEPTH-entry ordered queue;
  - per-entry kill-by-index input;
  - full/empty/head outputs;
  - youngest-match lookup port used for bypass.
- Top level holds the issue mux, output register and bypass muxing.

## Test plan
- Pipe write r5=0x1234 at N, no md → RegWr=1, wr_rd=5, busW=0x1234 at N+1; fwdA_hit=1 with rs=5 at N+1.
- md r7=0xAAAA at N, pipe writes r3 at N+1 and r4 at N+2 → r3 at N+2, r4 at N+3, r7 at N+4.
- Three md results back-to-back with pipe_wr held high → md_ready=0 after two accepts; third accepted after pipe_wr drops and head pops; all three written in order.
- md r9=0x1 queued, pipe write r9=0x2 next cycle → only 0x2 written to r9; bypass for r9 returns 0x2, never 0x1.
- md_rd=0 or pipe_rd=0 → no RegWr, count unchanged, fwd hit=0 for rs=0.
- Assert rst with 2 queued entries → RegWr=0 next cycle, queue empty, md_ready=0 during rst and 1 the cycle after release; no stale write afterwards.
